// File: rtl/uart_tx_framer_if.sv
// Byte-in / serial-out bundle for the UART transmit framer.
// master: byte source (drives data/valid, observes line and status).
// slave: the framer itself.
interface uart_tx_framer_if;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;
  logic [10:0] tx_frame;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_serial, tx_busy, tx_done, tx_frame
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_serial, tx_busy, tx_done, tx_frame
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: frames a byte as start/data/parity/stop and shifts it out LSB-first.
// Latency: start bit on the line 1 clock after accept; frame lasts 11*CLKS_PER_BIT clocks.
// Backpressure: tx_ready high only in IDLE; tx_valid while busy is ignored, never buffered.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic             clk,
  input logic             rst,
  uart_tx_framer_if.slave tx
);

  // Counter is at least one bit wide so CLKS_PER_BIT=1 still has a legal vector;
  // in that case it sits at 0 and wraps on every clock.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [3:0]       bit_idx_q;
  logic [3:0]       bit_idx_d;
  logic [10:0]      frame_q;
  logic             serial_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             parity;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  assign parity    = (^tx.tx_data) ^ PARITY_ODD;
  assign bit_idx_d = bit_idx_q + 4'd1;

  // Framer FSM: every output is a register so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      frame_q   <= 11'h400;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx.tx_valid) begin
            frame_q   <= {1'b1, parity, tx.tx_data, 1'b0};
            bit_idx_q <= '0;
            baud_q    <= '0;
            serial_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (baud_q == CNT_MAX) begin
            baud_q <= '0;
            if (bit_idx_q == LAST_BIT) begin
              // Stop bit finished: line is already high, hand control back.
              serial_q <= 1'b1;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_d;
              serial_q  <= frame_q[bit_idx_d];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_ready  = ready_q;
  assign tx.tx_serial = serial_q;
  assign tx.tx_busy   = busy_q;
  assign tx.tx_done   = done_q;
  assign tx.tx_frame  = frame_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three instances (4 clk/bit even, 2 clk/bit even,
// 1 clk/bit odd), a table of known frames, hand sequences for back-to-back,
// reset mid-frame and loopback, and a random run against a sample-queue model.
module tb_uart_tx_framer;

  localparam int CPB_A = 4;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miss_cnt;
  bit   mon_en;

  uart_tx_framer_if ifa ();
  uart_tx_framer_if ifb ();
  uart_tx_framer_if ifc ();

  uart_tx_framer #(.CLKS_PER_BIT(CPB_A), .PARITY_ODD(1'b0)) u_a (.clk(clk), .rst(rst), .tx(ifa));
  uart_tx_framer #(.CLKS_PER_BIT(2),     .PARITY_ODD(1'b0)) u_b (.clk(clk), .rst(rst), .tx(ifb));
  uart_tx_framer #(.CLKS_PER_BIT(1),     .PARITY_ODD(1'b1)) u_c (.clk(clk), .rst(rst), .tx(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [10:0] v, input int k);
    logic [10:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic logic [10:0] build_frame(input logic [7:0] d, input bit odd);
    logic p;
    p = (($countones(d) % 2) == 1) ^ odd;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic chk_idle(input string tag, input logic s, input logic r, input logic b,
                          input logic d, input logic [10:0] f);
    chk({tag, "_serial"}, 32'(s), 32'd1);
    chk({tag, "_ready"},  32'(r), 32'd1);
    chk({tag, "_busy"},   32'(b), 32'd0);
    chk({tag, "_done"},   32'(d), 32'd0);
    chk({tag, "_frame"},  32'(f), 32'h400);
  endtask

  // Reference for instance A: the expected line value for every remaining clock of the frame.
  bit          mq[$];
  logic        m_done;
  logic [10:0] m_frame;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_done  = 1'b0;
      m_frame = 11'h400;
    end else begin
      m_done = 1'b0;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end else if (ifa.tx_valid) begin
        m_frame = build_frame(ifa.tx_data, 1'b0);
        for (int k = 0; k < 11; k++)
          for (int j = 0; j < CPB_A; j++) mq.push_back(bit_of(m_frame, k));
      end
    end
  end

  // Cycle-by-cycle comparison of instance A against the reference.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_serial", 32'(ifa.tx_serial), 32'((mq.size() == 0) ? 1'b1 : mq[0]));
      chk("mon_ready",  32'(ifa.tx_ready),  32'(mq.size() == 0));
      chk("mon_busy",   32'(ifa.tx_busy),   32'(mq.size() != 0));
      chk("mon_done",   32'(ifa.tx_done),   32'(m_done));
      chk("mon_frame",  32'(ifa.tx_frame),  32'(m_frame));
    end
  end

  // Send one byte on A and check the whole frame as seen on the line.
  task automatic run_a(input logic [7:0] d, input logic [10:0] fr, input bit loop_fields);
    int          c;
    logic [10:0] rxf;
    @(negedge clk);
    ifa.tx_valid = 1'b1;
    ifa.tx_data  = d;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ifa.tx_busy && c < 8);
    chk("a_accept", 32'(ifa.tx_busy), 32'd1);
    ifa.tx_valid = 1'b0;
    ifa.tx_data  = 8'($urandom);
    chk("a_frame", 32'(ifa.tx_frame), 32'(fr));
    c   = 0;
    rxf = '0;
    while (ifa.tx_busy && c < 200) begin
      if (c < 11 * CPB_A) begin
        chk("a_line", 32'(ifa.tx_serial), 32'(bit_of(fr, c / CPB_A)));
        if ((c % CPB_A) == CPB_A / 2) rxf = rxf | (11'(ifa.tx_serial) << (c / CPB_A));
      end
      ifa.tx_data = 8'($urandom);
      c++;
      @(negedge clk);
    end
    chk("a_busy_len",   32'(c), 32'(11 * CPB_A));
    chk("a_done",       32'(ifa.tx_done), 32'd1);
    chk("a_ready_done", 32'(ifa.tx_ready), 32'd1);
    chk("a_rx_frame",   32'(rxf), 32'(fr));
    if (loop_fields) begin
      chk("loop_start",  32'(ifa.tx_frame[0]),   32'd0);
      chk("loop_data",   32'(ifa.tx_frame[8:1]), 32'(d));
      chk("loop_parity", 32'(ifa.tx_frame[9]),   32'd0);
      chk("loop_stop",   32'(ifa.tx_frame[10]),  32'd1);
    end
    @(negedge clk);
    chk("a_done_once", 32'(ifa.tx_done), 32'd0);
  endtask

  initial begin
    logic [10:0] fr_b1;
    logic [10:0] fr_c;
    int          c;

    vec_cnt  = 0;
    miss_cnt = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0;
    ifc.tx_valid = 1'b0; ifc.tx_data = '0;

    vecs[0] = '{8'hA5, 11'h54A};
    vecs[1] = '{8'h07, 11'h60E};
    vecs[2] = '{8'h00, 11'h400};
    vecs[3] = '{8'hFF, 11'h5FE};
    vecs[4] = '{8'h5A, 11'h4B4};
    vecs[5] = '{8'h81, 11'h502};
    vecs[6] = '{8'h01, 11'h602};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("rst_a", ifa.tx_serial, ifa.tx_ready, ifa.tx_busy, ifa.tx_done, ifa.tx_frame);
      chk_idle("rst_b", ifb.tx_serial, ifb.tx_ready, ifb.tx_busy, ifb.tx_done, ifb.tx_frame);
      chk_idle("rst_c", ifc.tx_serial, ifc.tx_ready, ifc.tx_busy, ifc.tx_done, ifc.tx_frame);
    end

    // Table of known frames
    for (int i = 0; i < 7; i++) run_a(vecs[i].data, vecs[i].frame, vecs[i].data == 8'h5A);

    // Odd parity and one clock per bit
    fr_c = 11'h40E;
    @(negedge clk);
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'h07;
    @(negedge clk);
    ifc.tx_valid = 1'b0;
    chk("c_busy",   32'(ifc.tx_busy), 32'd1);
    chk("c_frame",  32'(ifc.tx_frame), 32'h40E);
    chk("c_parity", 32'(ifc.tx_frame[9]), 32'd0);
    for (int k = 0; k < 11; k++) begin
      chk("c_line", 32'(ifc.tx_serial), 32'(bit_of(fr_c, k)));
      @(negedge clk);
    end
    chk("c_done",   32'(ifc.tx_done), 32'd1);
    chk("c_idle",   32'(ifc.tx_serial), 32'd1);
    chk("c_bsyoff", 32'(ifc.tx_busy), 32'd0);

    // Back-to-back on B with tx_valid held high
    fr_b1 = 11'h400;
    @(negedge clk);
    ifb.tx_valid = 1'b1;
    ifb.tx_data  = 8'h00;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ifb.tx_busy && c < 8);
    chk("b_accept", 32'(ifb.tx_busy), 32'd1);
    for (int k = 0; k < 22; k++) begin
      chk("b_line1", 32'(ifb.tx_serial), 32'(bit_of(fr_b1, k / 2)));
      if (k == 10) ifb.tx_data = 8'hFF;
      @(negedge clk);
    end
    chk("b_done",   32'(ifb.tx_done), 32'd1);
    chk("b_ready",  32'(ifb.tx_ready), 32'd1);
    chk("b_gap",    32'(ifb.tx_serial), 32'd1);
    chk("b_frame1", 32'(ifb.tx_frame), 32'h400);
    @(negedge clk);
    ifb.tx_valid = 1'b0;
    chk("b_start2", 32'(ifb.tx_serial), 32'd0);
    chk("b_busy2",  32'(ifb.tx_busy), 32'd1);
    chk("b_done2",  32'(ifb.tx_done), 32'd0);
    chk("b_frame2", 32'(ifb.tx_frame), 32'h5FE);
    c = 0;
    while (!ifb.tx_done && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("b_len2",    32'(c), 32'd22);
    chk("b_frame2e", 32'(ifb.tx_frame), 32'h5FE);

    // Reset in the third data bit of 0x3C
    @(negedge clk);
    ifa.tx_valid = 1'b1;
    ifa.tx_data  = 8'h3C;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    chk("r_busy", 32'(ifa.tx_busy), 32'd1);
    repeat (3 * CPB_A) @(negedge clk);
    chk("r_bit3", 32'(ifa.tx_serial), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_serial", 32'(ifa.tx_serial), 32'd1);
    chk("r_ready",  32'(ifa.tx_ready), 32'd1);
    chk("r_busy0",  32'(ifa.tx_busy), 32'd0);
    chk("r_done",   32'(ifa.tx_done), 32'd0);
    @(negedge clk);
    chk("r_nodone", 32'(ifa.tx_done), 32'd0);
    run_a(8'h81, 11'h502, 1'b0);

    // Random traffic, including occasional resets, checked by the model
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      ifa.tx_valid = ($urandom_range(0, 3) != 0);
      ifa.tx_data  = 8'($urandom);
      rst          = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst          = 1'b0;
    ifa.tx_valid = 1'b0;
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
